// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge: FSM encoding,
// the error word returned on a bus timeout, and address alignment.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dmem_bridge_state_t;

  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEADBEEF;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Core dmem port plus valid/ready memory bus, bundled for the bridge.
// master = bridge side, slave = core/bus environment side.
interface dmem_bridge_if;

  logic [31:0] dmem_addr_in;
  logic [31:0] dmem_data_in;
  logic [3:0]  dmem_write_enable_in;
  logic        dmem_read_in;
  logic [31:0] dmem_data_out;
  logic        stall_out;

  logic        mem_valid_out;
  logic        mem_ready_in;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [3:0]  mem_wstrb_out;
  logic        mem_rvalid_in;
  logic [31:0] mem_rdata_in;
  logic        err_out;

  modport master (
    input  dmem_addr_in, dmem_data_in, dmem_write_enable_in, dmem_read_in,
    input  mem_ready_in, mem_rvalid_in, mem_rdata_in,
    output dmem_data_out, stall_out,
    output mem_valid_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wstrb_out,
    output err_out
  );

  modport slave (
    output dmem_addr_in, dmem_data_in, dmem_write_enable_in, dmem_read_in,
    output mem_ready_in, mem_rvalid_in, mem_rdata_in,
    input  dmem_data_out, stall_out,
    input  mem_valid_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_wstrb_out,
    input  err_out
  );

endinterface

// File: rtl/dmem_bridge_watchdog_counter.sv
// Cycle counter that flags expiry once it reaches TIMEOUT_CYCLES.
// With TIMEOUT_CYCLES = 0 no counter exists and it never expires.
module watchdog_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk_in, rst_n_in, clear, enable};
      assign expired = 1'b0;
    end else begin : g_on
      localparam int W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

      logic [W-1:0] count_reg;

      // Saturates at LIMIT so a stalled enable cannot wrap past expiry
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          count_reg <= '0;
        end else if (clear) begin
          count_reg <= '0;
        end else if (enable && (count_reg != LIMIT)) begin
          count_reg <= count_reg + 1'b1;
        end
      end

      assign expired = (count_reg == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the core's single-cycle dmem port onto a variable-latency
// valid/ready bus, stalling the core while a transaction is in flight.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic           clk_in,
  input logic           rst_n_in,
  dmem_bridge_if.master bus
);

  dmem_bridge_state_t state_reg, state_next;

  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic        we_reg;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;

  logic request;
  logic latch_en;
  logic wd_clear;
  logic wd_enable;
  logic expired;
  logic stall;
  logic valid;

  assign request = (|bus.dmem_write_enable_in) || bus.dmem_read_in;

  watchdog_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clear    (wd_clear),
    .enable   (wd_enable),
    .expired  (expired)
  );

  always_comb begin
    state_next = state_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
    latch_en   = 1'b0;
    wd_clear   = 1'b0;
    wd_enable  = 1'b0;
    stall      = 1'b0;
    valid      = 1'b0;

    case (state_reg)
      IDLE: begin
        stall = request;
        if (request) begin
          latch_en   = 1'b1;
          wd_clear   = 1'b1;
          state_next = REQ;
        end
      end

      REQ: begin
        stall     = 1'b1;
        wd_enable = 1'b1;
        // Timeout outranks a same-cycle ready: the request is withdrawn
        if (expired) begin
          rdata_next = DMEM_ERR_DATA;
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          valid = 1'b1;
          if (bus.mem_ready_in) begin
            state_next = we_reg ? DONE : WAIT;
          end
        end
      end

      WAIT: begin
        stall     = 1'b1;
        wd_enable = 1'b1;
        if (expired) begin
          rdata_next = DMEM_ERR_DATA;
          err_next   = 1'b1;
          state_next = DONE;
        end else if (bus.mem_rvalid_in) begin
          rdata_next = bus.mem_rdata_in;
          state_next = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      we_reg    <= 1'b0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
      // A read-only request has zero strobes, so wstrb is naturally 0 for reads
      if (latch_en) begin
        addr_reg  <= word_align(bus.dmem_addr_in);
        wdata_reg <= bus.dmem_data_in;
        wstrb_reg <= bus.dmem_write_enable_in;
        we_reg    <= |bus.dmem_write_enable_in;
      end
    end
  end

  assign bus.stall_out     = stall;
  assign bus.mem_valid_out = valid;
  assign bus.mem_we_out    = we_reg;
  assign bus.mem_addr_out  = addr_reg;
  assign bus.mem_wdata_out = wdata_reg;
  assign bus.mem_wstrb_out = wstrb_reg;
  assign bus.dmem_data_out = rdata_reg;
  assign bus.err_out       = err_reg;

endmodule
